serial_add_ctrl: RTL and testbench

Sequencing controller that performs W-bit add/subtract by time-multiplexing one combinational 4-bit ripple-carry slice over NIBBLES cycles, LSB nibble first. A registered carry links the nibbles. Accepts operands on a valid/ready handshake and returns the result on a second valid/ready handshake. Sits between board I/O (SW/KEY capture logic) and display/LED logic; it trades adder area for multi-cycle latency.

---
 rtl/serial_add_ctrl_pkg.sv | 17 +
 rtl/serial_add_ctrl_if.sv | 41 ++++
 rtl/serial_add_ctrl_slice.sv | 46 ++++
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_serial_add_ctrl.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the nibble-serial add/subtract controller:
//   - SLICE_W : width of the single combinational adder slice
//   - state_t : controller FSM states (IDLE / RUN / DONE, 2-bit encoding)
// -----------------------------------------------------------------------------
package serial_add_pkg;

   localparam int SLICE_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Operand / result handshake bundle for serial_add_ctrl.
//   Operand side : in_valid, in_ready, a, b, cin, sub
//   Result side  : out_valid, out_ready, sum, cout, overflow
//   Status       : busy
// Modports:
//   slave  - the controller (accepts operands, produces results)
//   master - the producer/consumer driving operands and taking results
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if #(
   parameter int NIBBLES = 4
);
   import serial_add_pkg::*;

   localparam int W = SLICE_W * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         overflow;
   logic         busy;

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, overflow, busy
   );

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, overflow, busy
   );

endinterface

// File: rtl/serial_add_ctrl_slice.sv
// -----------------------------------------------------------------------------
// nibble_add_slice
// Combinational SLICE_W-bit ripple-carry adder built from 1-bit full-adder
// cells. This is the one and only adder datapath in the controller.
//   a[3:0], b[3:0] : slice operands
//   ci             : carry in
//   s[3:0]         : slice sum
//   co             : carry out of the slice MSB
// -----------------------------------------------------------------------------
module full_add_cell (
   input  logic i_a,
   input  logic i_b,
   input  logic i_ci,
   output logic o_s,
   output logic o_co
);
   assign o_s  = i_a ^ i_b ^ i_ci;
   assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module nibble_add_slice
   import serial_add_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               ci,
   output logic [SLICE_W-1:0] s,
   output logic               co
);
   // w_c[i] is the carry into bit i; w_c[SLICE_W] leaves the slice
   logic [SLICE_W:0] w_c;

   assign w_c[0] = ci;

   for (genvar g = 0; g < SLICE_W; g++) begin : g_fa
      full_add_cell u_fa (
         .i_a  (a[g]),
         .i_b  (b[g]),
         .i_ci (w_c[g]),
         .o_s  (s[g]),
         .o_co (w_c[g+1])
      );
   end

   assign co = w_c[SLICE_W];
endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// W-bit (W = 4*NIBBLES) add/subtract performed one nibble per cycle, LSB
// nibble first, through a single shared 4-bit ripple-carry slice. A registered
// carry links consecutive nibbles.
//   CLOCK_50 : system clock, rising edge
//   reset    : synchronous, active-high, dominant
//   bus      : serial_add_ctrl_if.slave (operand and result handshakes)
// Latency: accept edge E0 -> out_valid after edge E_NIBBLES.
// in_ready / out_valid / busy decode straight from the state register;
// sum / cout / overflow are registers.
// -----------------------------------------------------------------------------
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic              CLOCK_50,
   input  logic              reset,
   serial_add_ctrl_if.slave  bus
);
   localparam int W     = SLICE_W * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NIBBLES - 1);

   state_t             r_state;
   logic [IDX_W-1:0]   r_idx;
   logic [W-1:0]       r_op_a;
   logic [W-1:0]       r_op_b;   // already inverted for subtract
   logic               r_carry;
   logic [W-1:0]       r_sum;
   logic               r_cout;
   logic               r_ovf;

   logic [SLICE_W-1:0] w_sl_a;
   logic [SLICE_W-1:0] w_sl_b;
   logic [SLICE_W-1:0] w_sl_s;
   logic               w_sl_co;

   // Nibble currently being processed
   assign w_sl_a = r_op_a[SLICE_W*r_idx +: SLICE_W];
   assign w_sl_b = r_op_b[SLICE_W*r_idx +: SLICE_W];

   nibble_add_slice u_slice (
      .a  (w_sl_a),
      .b  (w_sl_b),
      .ci (r_carry),
      .s  (w_sl_s),
      .co (w_sl_co)
   );

   // Controller FSM and datapath registers
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_idx   <= '0;
         r_op_a  <= '0;
         r_op_b  <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  // Subtract is a + ~b + 1: invert B here, seed carry with 1
                  r_op_a  <= bus.a;
                  r_op_b  <= bus.sub ? ~bus.b : bus.b;
                  r_carry <= bus.sub ? 1'b1 : bus.cin;
                  r_idx   <= '0;
                  r_sum   <= '0;
                  r_state <= ST_RUN;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            ST_RUN: begin
               r_sum[SLICE_W*r_idx +: SLICE_W] <= w_sl_s;
               r_carry <= w_sl_co;
               // Only the value written on the last nibble is meaningful:
               // same-sign operands whose result sign differs overflowed.
               r_ovf   <= (r_op_a[W-1] == r_op_b[W-1]) &&
                          (w_sl_s[SLICE_W-1] != r_op_a[W-1]);
               if (r_idx == IDX_LAST) begin
                  // idx parks on the last nibble; next accept clears it
                  r_cout  <= w_sl_co;
                  r_state <= ST_DONE;
               end else begin
                  r_idx   <= r_idx + 1'b1;
               end
            end
            ST_DONE: begin
               if (bus.out_ready) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_state <= ST_DONE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = (r_state == ST_IDLE);
   assign bus.out_valid = (r_state == ST_DONE);
   assign bus.busy      = (r_state != ST_IDLE);
   assign bus.sum       = r_sum;
   assign bus.cout      = r_cout;
   assign bus.overflow  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Self-checking bench for serial_add_ctrl (NIBBLES=4, W=16). A behavioural
// model computes results with integer arithmetic and tracks the expected
// handshake phase; a negedge process compares the DUT against it every cycle.
// Directed operations also pin hand-computed literal results.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;
   localparam int NIBBLES = 4;
   localparam int W       = 16;

   logic CLOCK_50 = 1'b0;
   logic reset    = 1'b1;

   serial_add_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

   serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Reference arithmetic from the operation's meaning, not its structure
   function automatic void ref_op(input logic [15:0] x, input logic [15:0] y,
                                  input logic c, input logic s,
                                  output logic [15:0] rs, output logic rc, output logic ro);
      int ux, uy, sx, sy, ures, sres;
      ux = int'(x);
      uy = int'(y);
      sx = int'($signed(x));
      sy = int'($signed(y));
      if (s) begin
         ures = ux - uy;
         sres = sx - sy;
         rc   = (ux >= uy);
      end else begin
         ures = ux + uy + int'(c);
         sres = sx + sy + int'(c);
         rc   = (ures > 65535);
      end
      rs = ures[15:0];
      ro = (sres > 32767) || (sres < -32768);
   endfunction

   // Model state: phase 0=idle, 1=computing, 2=result presented
   int          m_phase = 0;
   int          m_cnt   = 0;
   logic [15:0] m_sum   = '0;
   logic        m_cout  = 1'b0;
   logic        m_ovf   = 1'b0;
   logic [15:0] p_sum;
   logic        p_cout, p_ovf;
   bit          m_started = 1'b0;

   // Behavioural model advances on each rising edge
   always @(posedge CLOCK_50) begin
      m_started <= 1'b1;
      if (reset) begin
         m_phase <= 0; m_cnt <= 0;
         m_sum <= '0; m_cout <= 1'b0; m_ovf <= 1'b0;
      end else if (m_phase == 0) begin
         if (bus.in_valid) begin
            ref_op(bus.a, bus.b, bus.cin, bus.sub, p_sum, p_cout, p_ovf);
            m_phase <= 1; m_cnt <= 0;
         end
      end else if (m_phase == 1) begin
         m_cnt <= m_cnt + 1;
         if (m_cnt + 1 == NIBBLES) begin
            m_phase <= 2;
            m_sum <= p_sum; m_cout <= p_cout; m_ovf <= p_ovf;
         end
      end else begin
         if (bus.out_ready) m_phase <= 0;
      end
   end

   // Compare DUT against the model on every falling edge
   always @(negedge CLOCK_50) begin
      if (m_started) begin
         chk("in_ready",  {31'd0, bus.in_ready},  {31'd0, m_phase == 0});
         chk("out_valid", {31'd0, bus.out_valid}, {31'd0, m_phase == 2});
         chk("busy",      {31'd0, bus.busy},      {31'd0, m_phase != 0});
         if (m_phase != 1) begin
            chk("sum",      {16'd0, bus.sum},       {16'd0, m_sum});
            chk("cout",     {31'd0, bus.cout},      {31'd0, m_cout});
            chk("overflow", {31'd0, bus.overflow},  {31'd0, m_ovf});
         end
      end
   end

   task automatic tick();
      @(posedge CLOCK_50);
      #1;
   endtask

   // Drive one operation from IDLE; checks latency, optional literal result,
   // holds the result for 'hold' cycles, then completes the handshake.
   task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_b,
                        input logic tcin, input logic tsub,
                        input bit lit, input logic [15:0] es,
                        input logic ec, input logic eo, input int hold);
      int cyc;
      bus.a = ta; bus.b = tb_b; bus.cin = tcin; bus.sub = tsub;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.a = 16'($urandom); bus.b = 16'($urandom);
      bus.cin = 1'($urandom); bus.sub = 1'($urandom);
      cyc = 0;
      while (!bus.out_valid && cyc < 20) begin
         bus.in_valid  = 1'($urandom);
         bus.out_ready = 1'($urandom);
         tick();
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      chk("latency", 32'(cyc), 32'(NIBBLES));
      if (lit) begin
         chk("lit_sum",  {16'd0, bus.sum},      {16'd0, es});
         chk("lit_cout", {31'd0, bus.cout},     {31'd0, ec});
         chk("lit_ovf",  {31'd0, bus.overflow}, {31'd0, eo});
      end
      for (int h = 0; h < hold; h++) begin
         bus.in_valid = 1'($urandom);
         tick();
         chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk("post_hs_in_ready", {31'd0, bus.in_ready}, 32'd1);
   endtask

   initial begin
      logic [15:0] ra, rb;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.sub = 1'b0;
      reset = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("rst_sum",       {16'd0, bus.sum},       32'd0);
      tick();

      do_op(16'h1234, 16'h0FFF, 1'b0, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0, 0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
      do_op(16'h0000, 16'hFFFF, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 0);
      do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
      do_op(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 3);

      // Abort on the second RUN cycle
      bus.a = 16'hABCD; bus.b = 16'h1111; bus.cin = 1'b0; bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
      chk("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("abort_sum",       {16'd0, bus.sum},       32'd0);
      do_op(16'h0001, 16'h0001, 1'b0, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0, 0);

      // Randomized operations against the model
      for (int i = 0; i < 30; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if (i % 5 == 0) rb = 16'hFFFF - ra;
         do_op(ra, rb, 1'($urandom), 1'($urandom), 1'b0, 16'd0, 1'b0, 1'b0,
               int'($urandom_range(0, 2)));
         repeat (int'($urandom_range(0, 2))) tick();
      end

      tick();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
